// File: rtl/raster_engine.sv
// Framebuffer rasterizer: draws CLEAR/PIXEL/LINE/RECT one pixel per cycle, then streams the frame row-major.
// Optional RASTER_XOR_EN adds cmd_xor_i so PIXEL/LINE/RECT writes XOR into the framebuffer.
module raster_engine #(
  parameter int COORD_W = 3,
  parameter int PIX_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [COORD_W-1:0] cmd_x1_i,
  input  logic [COORD_W-1:0] cmd_y1_i,
  input  logic [COORD_W-1:0] cmd_x2_i,
  input  logic [COORD_W-1:0] cmd_y2_i,
  input  logic [PIX_W-1:0]   cmd_color_i,
`ifdef RASTER_XOR_EN
  input  logic               cmd_xor_i,
`endif
  output logic               pix_valid_o,
  input  logic               pix_ready_i,
  output logic [PIX_W-1:0]   pix_data_o,
  output logic               frame_sync_o,
  output logic               pix_last_o,
  output logic               busy_o
);

  // state  | meaning
  // IDLE   | waiting for a command, cmd_ready_o high
  // CLEAR  | filling the whole grid row-major
  // PIXEL  | single write at (x1,y1)
  // LINE   | Bresenham walk, one pixel per cycle
  // RECT   | normalised rectangle fill, row-major
  // STREAM | sending the frame over the pixel port
  localparam int N    = 1 << COORD_W;
  localparam int NPIX = N * N;
  localparam int AW   = 2 * COORD_W;
  localparam int EW   = COORD_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_PIXEL, S_LINE, S_RECT, S_STREAM
  } state_t;

  state_t                   state_q;
  logic [PIX_W-1:0]         fb_q [NPIX];
  logic [COORD_W-1:0]       cx_q, cy_q, xlo_q, xhi_q, yhi_q;
  logic                     sxn_q, syn_q, xor_q;
  logic signed [EW-1:0]     dx_q, dy_q, err_q;
  logic [PIX_W-1:0]         color_q;
  logic [AW-1:0]            idx_q;

  logic [COORD_W-1:0]       xmin, xmax, ymin, ymax, adx, ady;
  logic signed [EW-1:0]     dx_init, dy_init, err_init;
  logic signed [EW:0]       e2;
  logic                     step_x, step_y, draw_done, xor_in;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr, idx_nxt;
  logic [PIX_W-1:0]         wr_data, first_pix;
  logic [COORD_W-1:0]       cx_step, cy_step;

  always_comb begin
    xmin     = (cmd_x1_i < cmd_x2_i) ? cmd_x1_i : cmd_x2_i;
    xmax     = (cmd_x1_i < cmd_x2_i) ? cmd_x2_i : cmd_x1_i;
    ymin     = (cmd_y1_i < cmd_y2_i) ? cmd_y1_i : cmd_y2_i;
    ymax     = (cmd_y1_i < cmd_y2_i) ? cmd_y2_i : cmd_y1_i;
    adx      = xmax - xmin;
    ady      = ymax - ymin;
    dx_init  = $signed({2'b00, adx});
    dy_init  = -$signed({2'b00, ady});
    err_init = dx_init + dy_init;
`ifdef RASTER_XOR_EN
    xor_in   = cmd_xor_i;
`else
    xor_in   = 1'b0;
`endif
    // Both compares are inclusive, so an error tie steps the minor axis too
    e2       = $signed({err_q, 1'b0});
    step_x   = e2 >= $signed({dy_q[EW-1], dy_q});
    step_y   = e2 <= $signed({dx_q[EW-1], dx_q});
    cx_step  = sxn_q ? cx_q - COORD_W'(1) : cx_q + COORD_W'(1);
    cy_step  = syn_q ? cy_q - COORD_W'(1) : cy_q + COORD_W'(1);
    wr_en    = (state_q == S_CLEAR) || (state_q == S_PIXEL) ||
               (state_q == S_LINE)  || (state_q == S_RECT);
    wr_addr  = {cy_q, cx_q};
    wr_data  = (xor_q && state_q != S_CLEAR) ? (fb_q[wr_addr] ^ color_q) : color_q;
    draw_done = (state_q == S_PIXEL) || (cx_q == xhi_q && cy_q == yhi_q);
    // The final draw write lands on the same edge the stream's first beat is loaded
    first_pix = (wr_en && wr_addr == '0) ? wr_data : fb_q[0];
    idx_nxt   = idx_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < NPIX; i++) fb_q[i] <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      xlo_q        <= '0;
      xhi_q        <= '0;
      yhi_q        <= '0;
      sxn_q        <= 1'b0;
      syn_q        <= 1'b0;
      xor_q        <= 1'b0;
      dx_q         <= '0;
      dy_q         <= '0;
      err_q        <= '0;
      color_q      <= '0;
      idx_q        <= '0;
      cmd_ready_o  <= 1'b1;
      pix_valid_o  <= 1'b0;
      pix_data_o   <= '0;
      frame_sync_o <= 1'b0;
      pix_last_o   <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      if (wr_en) fb_q[wr_addr] <= wr_data;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            color_q     <= cmd_color_i;
            xor_q       <= xor_in;
            dx_q        <= dx_init;
            dy_q        <= dy_init;
            err_q       <= err_init;
            sxn_q       <= cmd_x2_i < cmd_x1_i;
            syn_q       <= cmd_y2_i < cmd_y1_i;
            case (cmd_op_i)
              2'b00: begin
                state_q <= S_CLEAR;
                cx_q    <= '0;
                cy_q    <= '0;
                xlo_q   <= '0;
                xhi_q   <= '1;
                yhi_q   <= '1;
              end
              2'b01: begin
                state_q <= S_PIXEL;
                cx_q    <= cmd_x1_i;
                cy_q    <= cmd_y1_i;
                xlo_q   <= cmd_x1_i;
                xhi_q   <= cmd_x1_i;
                yhi_q   <= cmd_y1_i;
              end
              2'b10: begin
                state_q <= S_LINE;
                cx_q    <= cmd_x1_i;
                cy_q    <= cmd_y1_i;
                xlo_q   <= cmd_x1_i;
                xhi_q   <= cmd_x2_i;
                yhi_q   <= cmd_y2_i;
              end
              default: begin
                state_q <= S_RECT;
                cx_q    <= xmin;
                cy_q    <= ymin;
                xlo_q   <= xmin;
                xhi_q   <= xmax;
                yhi_q   <= ymax;
              end
            endcase
          end
        end
        S_CLEAR, S_PIXEL, S_LINE, S_RECT: begin
          if (draw_done) begin
            state_q      <= S_STREAM;
            idx_q        <= '0;
            pix_valid_o  <= 1'b1;
            pix_data_o   <= first_pix;
            frame_sync_o <= 1'b1;
            pix_last_o   <= 1'b0;
          end else if (state_q == S_LINE) begin
            if (step_x) cx_q <= cx_step;
            if (step_y) cy_q <= cy_step;
            err_q <= err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
          end else if (cx_q == xhi_q) begin
            cx_q <= xlo_q;
            cy_q <= cy_q + COORD_W'(1);
          end else begin
            cx_q <= cx_q + COORD_W'(1);
          end
        end
        S_STREAM: begin
          if (pix_ready_i) begin
            if (idx_q == {AW{1'b1}}) begin
              state_q      <= S_IDLE;
              pix_valid_o  <= 1'b0;
              pix_data_o   <= '0;
              frame_sync_o <= 1'b0;
              pix_last_o   <= 1'b0;
              cmd_ready_o  <= 1'b1;
              busy_o       <= 1'b0;
            end else begin
              idx_q        <= idx_nxt;
              pix_data_o   <= fb_q[idx_nxt];
              frame_sync_o <= 1'b0;
              pix_last_o   <= (idx_nxt == {AW{1'b1}});
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_engine.sv
// Directed bench for raster_engine (8x8, 4-bit colour): table of commands with hand-computed pixel masks,
// plus hand-written reset-abort and (with RASTER_XOR_EN) XOR sequences.
module tb_raster_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [2:0] cmd_x1 = '0, cmd_y1 = '0, cmd_x2 = '0, cmd_y2 = '0;
  logic [3:0] cmd_color = '0;
  logic       pix_valid;
  logic       pix_ready = 1'b0;
  logic [3:0] pix_data;
  logic       frame_sync, pix_last, busy;
`ifdef RASTER_XOR_EN
  logic       cmd_xor = 1'b0;
`endif

  always #5 clk = ~clk;

  raster_engine #(.COORD_W(3), .PIX_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_x1_i(cmd_x1), .cmd_y1_i(cmd_y1), .cmd_x2_i(cmd_x2), .cmd_y2_i(cmd_y2),
    .cmd_color_i(cmd_color),
`ifdef RASTER_XOR_EN
    .cmd_xor_i(cmd_xor),
`endif
    .pix_valid_o(pix_valid), .pix_ready_i(pix_ready), .pix_data_o(pix_data),
    .frame_sync_o(frame_sync), .pix_last_o(pix_last), .busy_o(busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  x1, y1, x2, y2;
    logic [3:0]  color;
    int          cycles;
    logic [63:0] mask;   // bit y*8+x set for every pixel the command writes
    bit          rnd;    // random pix_ready plus ignored cmd_valid during stream
  } vec_t;

  int         n_assert = 0;
  int         n_fail = 0;
  logic [3:0] model [64];
  vec_t       vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_frame_sync"}, frame_sync, 0);
    check({tag, "_pix_last"}, pix_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pix_data"}, pix_data, 0);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [2:0] x1, input logic [2:0] y1,
                          input logic [2:0] x2, input logic [2:0] y2, input logic [3:0] color,
                          input int exp_cycles);
    int g = 0;
    int c = 0;
    @(negedge clk);
    while (!cmd_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_op = op; cmd_x1 = x1; cmd_y1 = y1; cmd_x2 = x2; cmd_y2 = y2; cmd_color = color;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("cmd_ready_drop", cmd_ready, 0);
    check("busy_on", busy, 1);
    while (!pix_valid && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("draw_cycles", c, exp_cycles);
  endtask

  task automatic apply_model(input logic [3:0] color, input logic [63:0] mask);
    for (int i = 0; i < 64; i++)
      if (mask[i]) model[i] = color;
  endtask

  task automatic collect_frame(input bit rnd);
    int         i = 0;
    int         guard = 0;
    bit         stalled = 1'b0;
    bit         rdy;
    logic [3:0] pd = '0;
    logic       ps = 1'b0, pl = 1'b0;
    if (rnd) begin
      cmd_op = 2'd0;
      cmd_color = 4'hF;
    end
    while (i < 64 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (stalled) begin
        check($sformatf("stall_data_%0d", i), pix_data, pd);
        check($sformatf("stall_sync_%0d", i), frame_sync, ps);
        check($sformatf("stall_last_%0d", i), pix_last, pl);
      end
      check("pix_valid_held", pix_valid, 1);
      if (rnd) begin
        check("cmd_ready_stream", cmd_ready, 0);
        cmd_valid = (i < 63);
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_ready = rdy;
      if (rdy) begin
        check($sformatf("beat_data_%0d", i), pix_data, model[i]);
        check($sformatf("beat_sync_%0d", i), frame_sync, (i == 0));
        check($sformatf("beat_last_%0d", i), pix_last, (i == 63));
        i++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pd = pix_data;
        ps = frame_sync;
        pl = pix_last;
      end
    end
    if (i < 64) check("stream_timeout", i, 64);
    @(negedge clk);
    pix_ready = 1'b0;
    cmd_valid = 1'b0;
    check("end_pix_valid", pix_valid, 0);
    check("end_cmd_ready", cmd_ready, 1);
    check("end_busy", busy, 0);
    check("end_sync_last", {frame_sync, pix_last}, 0);
  endtask

  initial begin
    //           op    x1    y1    x2    y2    col  cyc  mask                   rnd
    vecs[0] = '{2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0, 64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[1] = '{2'd1, 3'd5, 3'd2, 3'd0, 3'd0, 4'hA, 1,  64'h0000_0000_0020_0000, 1'b0};
    vecs[2] = '{2'd2, 3'd0, 3'd0, 3'd7, 3'd3, 4'hF, 8,  64'h0000_0000_C030_0C03, 1'b0};
    vecs[3] = '{2'd0, 3'd2, 3'd6, 3'd1, 3'd4, 4'h0, 64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[4] = '{2'd2, 3'd7, 3'd3, 3'd0, 3'd0, 4'hF, 8,  64'h0000_0000_C030_0C03, 1'b0};
    vecs[5] = '{2'd3, 3'd6, 3'd5, 3'd3, 3'd2, 4'h3, 16, 64'h0000_7878_7878_0000, 1'b1};
    vecs[6] = '{2'd2, 3'd2, 3'd7, 3'd3, 3'd0, 4'h5, 8,  64'h0404_0404_0808_0808, 1'b1};
    vecs[7] = '{2'd2, 3'd4, 3'd4, 3'd4, 3'd4, 4'h9, 1,  64'h0000_0010_0000_0000, 1'b0};
    vecs[8] = '{2'd3, 3'd1, 3'd7, 3'd1, 3'd6, 4'hC, 2,  64'h0202_0000_0000_0000, 1'b0};
    vecs[9] = '{2'd0, 3'd7, 3'd7, 3'd7, 3'd7, 4'h6, 64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    for (int i = 0; i < 64; i++) model[i] = 4'h0;

    #12;
    check_reset_outs("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      send_cmd(vecs[v].op, vecs[v].x1, vecs[v].y1, vecs[v].x2, vecs[v].y2, vecs[v].color, vecs[v].cycles);
      apply_model(vecs[v].color, vecs[v].mask);
      collect_frame(vecs[v].rnd);
    end

    // Reset in the middle of a full-grid RECT draw
    @(negedge clk);
    cmd_op = 2'd3; cmd_x1 = 3'd0; cmd_y1 = 3'd0; cmd_x2 = 3'd7; cmd_y2 = 3'd7; cmd_color = 4'h7;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("rst_rect");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = 4'h0;
    send_cmd(2'd1, 3'd7, 3'd7, 3'd0, 3'd0, 4'h1, 1);
    model[63] = 4'h1;
    collect_frame(1'b0);

    // Reset part-way through a stream
    send_cmd(2'd1, 3'd3, 3'd3, 3'd0, 3'd0, 4'h2, 1);
    @(negedge clk);
    pix_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    pix_ready = 1'b0;
    #1 check_reset_outs("rst_stream");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = 4'h0;
    send_cmd(2'd1, 3'd1, 3'd0, 3'd0, 3'd0, 4'h4, 1);
    model[1] = 4'h4;
    collect_frame(1'b0);

`ifdef RASTER_XOR_EN
    cmd_xor = 1'b1;
    send_cmd(2'd1, 3'd2, 3'd2, 3'd0, 3'd0, 4'hA, 1);
    model[18] = 4'hA;
    collect_frame(1'b0);
    send_cmd(2'd1, 3'd2, 3'd2, 3'd0, 3'd0, 4'hA, 1);
    model[18] = 4'h0;
    collect_frame(1'b0);
    cmd_xor = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
